coin_acceptor: RTL and testbench
================================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4: the number of consecutive stable synchronized samples (range 2..255) a coin line needs before its debounced level changes.
REQ-002 The block SHALL have parameter QDEPTH, default 4: the coin queue depth (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port raw_nickel, input, 1 bit: asynchronous, bouncy Rs.5 coin sensor; high while a coin passes.
REQ-006 The block SHALL have port raw_dime, input, 1 bit: asynchronous, bouncy Rs.10 coin sensor.
REQ-007 The block SHALL have port accept_en, input, 1 bit: when high, the downstream vending FSM can take a coin this cycle.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous request to return all queued coins.
REQ-009 The block SHALL have port coin, output, 2 bits: coin code to the vending FSM; 2'b01 = Rs.5, 2'b10 = Rs.10, 2'b00 = none; 2'b11 never driven.
REQ-010 The block SHALL have port reject, output, 1 bit: one-cycle pulse per coin routed to the return chute.
REQ-011 The block SHALL have port pending, output, clog2(QDEPTH)+1 bits: the current queue occupancy.

Function
REQ-012 Each raw line SHALL pass through a two-flop synchronizer before any other logic.
REQ-013 Each line's debouncer SHALL hold a debounced level and a counter.
  - Counter increments while the synchronized value differs from the debounced level.
  - Counter clears to 0 whenever they match.
  - When the counter reaches DEB_CYCLES, the debounced level takes the synchronized value and the counter clears.
REQ-014 A 0->1 transition of a debounced level SHALL generate exactly one coin event for that denomination; 1->0 transitions generate none.
REQ-015 Coin events SHALL be written into a FIFO of QDEPTH 2-bit entries. When both denominations produce events in the same cycle, the nickel is enqueued first and the dime second.
REQ-016 An event arriving when no free slot remains SHALL NOT be enqueued and SHALL pulse reject for one cycle. For simultaneous events with one free slot, the nickel is stored and the dime is rejected.
REQ-017 reject SHALL be registered and assert in the cycle after the overflow event. Two overflow events in the same cycle produce two pulses on consecutive cycles.
REQ-018 When the FIFO is non-empty and accept_en=1, the head entry SHALL be popped and driven on coin, registered, for exactly one cycle. coin is 2'b00 in every other cycle.
REQ-019 At most one coin SHALL be presented per cycle; consecutive non-empty cycles with accept_en=1 present coins back-to-back.
REQ-020 With accept_en=0, queued coins SHALL be held and coin SHALL be 2'b00; incoming events still enqueue.
REQ-021 Push and pop in the same cycle SHALL be allowed. When the FIFO is full, a simultaneous pop frees a slot for that cycle's push.
REQ-022 flush=1 SHALL empty the FIFO at the next edge, emit one reject pulse per flushed entry on consecutive cycles, and drive coin=2'b00 that cycle.
REQ-023 A coin event in the same cycle as flush SHALL be rejected, not enqueued.
REQ-024 Latency SHALL be exactly DEB_CYCLES+3 edges from the first edge that samples a clean raw high to the cycle coin is driven, with empty FIFO and accept_en=1.
REQ-025 pending SHALL reflect occupancy after each edge and wrap-free pointer arithmetic; pending never exceeds QDEPTH.

Reset
REQ-026 On reset_n=0, asynchronously and regardless of clock, the block SHALL clear: synchronizers, debounced levels, counters, FIFO pointers, occupancy, pending reject count, coin=2'b00, reject=0, pending=0.
REQ-027 Reset asserted mid-queue SHALL discard queued coins without reject pulses; after release, no event fires for a raw line already high until it first goes low.

Verification
REQ-028 DEB_CYCLES=4, raw_nickel high for 20 cycles with 3 bounce glitches in its first 3 cycles, accept_en=1 -> exactly one coin=2'b01 pulse, no reject.
REQ-029 raw_dime clean high, accept_en=1, empty queue -> coin=2'b10 on edge 7 exactly, one cycle wide, pending returns to 0.
REQ-030 accept_en=0, six clean coins alternating nickel/dime -> pending=4, two reject pulses. Then accept_en=1 -> 01,10,01,10 on four consecutive cycles.
REQ-031 Both lines rise together, queue holds 3, accept_en=0 -> nickel stored (pending=4), one reject pulse for the dime.
REQ-032 Queue holds 3, flush=1 for one cycle -> pending=0 next edge, three consecutive reject pulses, coin stays 2'b00.
REQ-033 reset_n pulled low asynchronously with 2 queued -> coin=00, reject=0, pending=0 immediately; no output until a new debounced rising edge.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes and debounces the Rs.5 / Rs.10 coin
// sensors, turns each debounced rising edge into a coin event, buffers events
// in a small FIFO and hands them to the vending FSM one per cycle. Coins that
// cannot be buffered, or that are flushed, are signalled on the reject line.
module coin_acceptor #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned QDEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      raw_nickel,
  input  logic                      raw_dime,
  input  logic                      accept_en,
  input  logic                      flush,
  output logic [1:0]                coin,
  output logic                      reject,
  output logic [$clog2(QDEPTH):0]   pending
);

  localparam int unsigned AW       = $clog2(QDEPTH);
  localparam int unsigned CW       = AW + 1;
  localparam logic [7:0]  DEB_LAST = 8'(DEB_CYCLES - 1);

  // Line index 0 is the nickel sensor, index 1 the dime sensor.
  logic [1:0]    w_raw;
  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_warm;
  logic [1:0]    r_lvl;
  logic [1:0]    r_arm;
  logic [7:0]    r_cnt [2];
  logic [1:0]    w_ev;

  logic [1:0]    r_mem [QDEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_rej_cnt;
  logic [1:0]    r_coin;
  logic          r_reject;

  logic          w_pop;
  logic [CW-1:0] w_free;
  logic          w_push_nk;
  logic          w_push_dm;
  logic [AW-1:0] w_wptr_dm;
  logic [1:0]    w_rej_new;
  logic [8:0]    w_rej_sum;
  logic [7:0]    w_rej_total;

  assign w_raw = {raw_dime, raw_nickel};

  // Two-flop synchronizers for both asynchronous sensor lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // Counts the edges after reset until r_s2 carries real sensor samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_warm <= '0;
    end else if (r_warm != 2'd2) begin
      r_warm <= r_warm + 2'd1;
    end
  end

  // Debouncers; a line is armed only once it has been seen low after reset, so
  // a coin stuck in the sensor across reset is never counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lvl <= '0;
      r_arm <= '0;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] != r_lvl[i]) begin
          if (r_cnt[i] == DEB_LAST) begin
            r_lvl[i] <= r_s2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
        if (r_warm == 2'd2 && !r_s2[i] && !r_lvl[i]) begin
          r_arm[i] <= 1'b1;
        end
      end
    end
  end

  // Coin events fire in the cycle whose edge flips the debounced level 0->1.
  always_comb begin
    w_ev = '0;
    for (int i = 0; i < 2; i++) begin
      w_ev[i] = r_arm[i] & r_s2[i] & ~r_lvl[i] & (r_cnt[i] == DEB_LAST);
    end
  end

  // Push/pop arbitration and reject accounting.
  always_comb begin
    w_pop       = (r_count != '0) && accept_en && !flush;
    // A same-cycle pop frees a slot for this cycle's push.
    w_free      = CW'(QDEPTH) - r_count + CW'(w_pop);
    w_push_nk   = w_ev[0] && !flush && (w_free != '0);
    w_push_dm   = w_ev[1] && !flush && (w_free > CW'(w_push_nk));
    w_wptr_dm   = r_wptr + AW'(w_push_nk);
    w_rej_new   = 2'(w_ev[0] & ~w_push_nk) + 2'(w_ev[1] & ~w_push_dm);
    w_rej_sum   = 9'(r_rej_cnt) + 9'(w_rej_new) + (flush ? 9'(r_count) : 9'd0);
    w_rej_total = w_rej_sum[8] ? 8'hff : w_rej_sum[7:0];
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_nk) begin
      r_mem[r_wptr] <= 2'b01;
    end
    if (w_push_dm) begin
      r_mem[w_wptr_dm] <= 2'b10;
    end
  end

  // FIFO pointers, occupancy and the registered coin output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_coin  <= 2'b00;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_coin  <= 2'b00;
    end else begin
      r_wptr  <= r_wptr + AW'(w_push_nk) + AW'(w_push_dm);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_count <= r_count + CW'(w_push_nk) + CW'(w_push_dm) - CW'(w_pop);
      r_coin  <= w_pop ? r_mem[r_rptr] : 2'b00;
    end
  end

  // Reject pulse train: one cycle per outstanding rejected coin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rej_cnt <= '0;
      r_reject  <= 1'b0;
    end else if (w_rej_total != '0) begin
      r_rej_cnt <= w_rej_total - 8'd1;
      r_reject  <= 1'b1;
    end else begin
      r_rej_cnt <= '0;
      r_reject  <= 1'b0;
    end
  end

  assign coin    = r_coin;
  assign reject  = r_reject;
  assign pending = r_count;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: scenarios push expected coin codes into a
// queue, a negedge monitor pops and compares whenever a coin is presented.
module tb_coin_acceptor;

  logic       clk;
  logic       reset_n;
  logic       raw_nickel;
  logic       raw_dime;
  logic       accept_en;
  logic       flush;
  logic [1:0] coin;
  logic       reject;
  logic [2:0] pending;

  int n_checks;
  int n_errors;
  int rej_seen;
  int coin_seen;
  logic [1:0] exp_q [$];

  coin_acceptor #(
    .DEB_CYCLES(4),
    .QDEPTH    (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_nickel(raw_nickel),
    .raw_dime  (raw_dime),
    .accept_en (accept_en),
    .flush     (flush),
    .coin      (coin),
    .reject    (reject),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every presented coin must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (reject) rej_seen++;
      if (coin != 2'b00) begin
        coin_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_coin: got %b, required none", coin);
        end else begin
          check("coin_order", int'(coin), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean coin on the lines selected by mask (bit0 nickel, bit1 dime).
  task automatic coin_pulse(input logic [1:0] mask, input int hi);
    @(negedge clk);
    raw_nickel = mask[0];
    raw_dime   = mask[1];
    tick(hi);
    raw_nickel = 1'b0;
    raw_dime   = 1'b0;
    tick(12);
  endtask

  initial begin
    int first_edge;
    int width;
    logic [1:0] vec [4];

    n_checks = 0; n_errors = 0; rej_seen = 0; coin_seen = 0;
    reset_n = 1'b0; raw_nickel = 1'b0; raw_dime = 1'b0;
    accept_en = 1'b0; flush = 1'b0;
    #2;
    check("reset_coin", int'(coin), 0);
    check("reset_reject", int'(reject), 0);
    check("reset_pending", int'(pending), 0);
    tick(2);
    reset_n = 1'b1;
    tick(5);

    // Latency: dime clean high, empty queue, accept_en=1.
    accept_en = 1'b1;
    exp_q.push_back(2'b10);
    @(negedge clk);
    raw_dime = 1'b1;
    first_edge = 0;
    width = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (coin == 2'b10) begin
        width++;
        if (first_edge == 0) first_edge = e;
      end
    end
    check("latency_edge", first_edge, 7);
    check("latency_width", width, 1);
    @(negedge clk);
    raw_dime = 1'b0;
    tick(12);
    check("latency_pending", int'(pending), 0);

    // Bouncy nickel: three glitches then steady high.
    rej_seen = 0; coin_seen = 0;
    exp_q.push_back(2'b01);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      raw_nickel = 1'b1;
      #3 raw_nickel = 1'b0;
      #3 raw_nickel = 1'b1;
      @(negedge clk);
    end
    tick(17);
    raw_nickel = 1'b0;
    tick(12);
    check("bounce_coins", coin_seen, 1);
    check("bounce_rejects", rej_seen, 0);

    // Six coins while held off: four queued, two rejected, then drained.
    accept_en = 1'b0;
    rej_seen = 0; coin_seen = 0;
    for (int i = 0; i < 6; i++) coin_pulse((i % 2 == 0) ? 2'b01 : 2'b10, 8);
    check("overflow_pending", int'(pending), 4);
    check("overflow_rejects", rej_seen, 2);
    vec[0] = 2'b01; vec[1] = 2'b10; vec[2] = 2'b01; vec[3] = 2'b10;
    for (int i = 0; i < 4; i++) exp_q.push_back(vec[i]);
    accept_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_coin", int'(coin), int'(vec[i]));
    end
    @(negedge clk);
    check("drain_idle", int'(coin), 0);
    check("drain_pending", int'(pending), 0);
    check("drain_count", coin_seen, 4);

    // Simultaneous events into an empty queue: nickel first.
    accept_en = 1'b0;
    coin_seen = 0;
    coin_pulse(2'b11, 8);
    check("both_pending", int'(pending), 2);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    accept_en = 1'b1;
    tick(4);
    check("both_count", coin_seen, 2);

    // Simultaneous events with one free slot: nickel kept, dime rejected.
    accept_en = 1'b0;
    rej_seen = 0; coin_seen = 0;
    coin_pulse(2'b10, 8);
    coin_pulse(2'b01, 8);
    coin_pulse(2'b10, 8);
    check("onefree_pre", int'(pending), 3);
    coin_pulse(2'b11, 8);
    check("onefree_pending", int'(pending), 4);
    check("onefree_rejects", rej_seen, 1);
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    accept_en = 1'b1;
    tick(6);
    check("onefree_count", coin_seen, 4);
    check("onefree_empty", int'(pending), 0);

    // Flush of three queued coins.
    accept_en = 1'b0;
    coin_pulse(2'b01, 8);
    coin_pulse(2'b10, 8);
    coin_pulse(2'b01, 8);
    check("flush_pre", int'(pending), 3);
    rej_seen = 0; coin_seen = 0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_pending", int'(pending), 0);
    check("flush_coin", int'(coin), 0);
    check("flush_rej0", int'(reject), 1);
    @(negedge clk);
    check("flush_rej1", int'(reject), 1);
    @(negedge clk);
    check("flush_rej2", int'(reject), 1);
    @(negedge clk);
    check("flush_rej3", int'(reject), 0);
    tick(1);
    check("flush_rejects", rej_seen, 3);
    check("flush_coins", coin_seen, 0);

    // Asynchronous reset with two queued coins and nickel stuck high.
    coin_pulse(2'b01, 8);
    coin_pulse(2'b10, 8);
    check("rst_pre", int'(pending), 2);
    @(negedge clk);
    raw_nickel = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_pending", int'(pending), 0);
    check("rst_coin", int'(coin), 0);
    check("rst_reject", int'(reject), 0);
    #4 reset_n = 1'b1;
    accept_en = 1'b1;
    coin_seen = 0; rej_seen = 0;
    tick(20);
    check("stuck_coins", coin_seen, 0);
    check("stuck_pending", int'(pending), 0);
    raw_nickel = 1'b0;
    tick(12);
    check("stuck_release", coin_seen, 0);
    exp_q.push_back(2'b01);
    coin_pulse(2'b01, 8);
    check("post_rst_coin", coin_seen, 1);
    check("post_rst_rejects", rej_seen, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
